mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_array.sv | 24 ++
 rtl/mem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the wait-stated CPU memory responder.
// Holds the FSM state encoding and the default geometry/timing constants.
package mem_responder_pkg;

    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned DEFAULT_ADDR_BITS   = 8;
    localparam int unsigned WAIT_CNT_BITS       = 4;
    localparam int unsigned DATA_BITS           = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESPOND,
        RELEASE
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: write-enable, registered read, no reset.
// Read_Data always reflects the word at the address presented on the previous edge.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic                 Clk,
    input  logic                 Write_En,
    input  logic [ADDR_BITS-1:0] Addr,
    input  logic [DATA_BITS-1:0] Write_Data,
    output logic [DATA_BITS-1:0] Read_Data
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge Clk) begin
        if (Write_En) begin
            mem[Addr] <= Write_Data;
        end
        Read_Data <= mem[Addr];
    end

endmodule

// File: rtl/mem_responder.sv
// CPU memory responder: latches a request, inserts WAIT_CYCLES wait states,
// performs one RAM access, strobes Ready for one cycle, then waits for release.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned ADDR_BITS   = DEFAULT_ADDR_BITS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid,
    input  logic        Req_Write,
    input  logic [15:0] Addr,
    input  logic [15:0] Data_From_CPU,
    output logic [15:0] Data_to_CPU,
    output logic        Ready,
    output logic        Busy
);

    state_t                   state;
    state_t                   state_next;
    logic [WAIT_CNT_BITS-1:0] wait_cnt;
    logic [ADDR_BITS-1:0]     lat_addr;
    logic                     lat_write;
    logic [DATA_BITS-1:0]     lat_data;
    logic                     accept;

    logic [ADDR_BITS-1:0]     ram_addr;
    logic                     ram_we;
    logic [DATA_BITS-1:0]     ram_rdata;

    assign accept = (state == IDLE) && Req_Valid;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Req_Valid) begin
                    state_next = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt <= WAIT_CNT_BITS'(1)) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESPOND;
            RESPOND: state_next = RELEASE;
            RELEASE: begin
                if (!Req_Valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= WAIT_CNT_BITS'(WAIT_CYCLES);
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_CNT_BITS'(1);
        end
    end

    // Request latches are not reset: they are only consumed after a fresh accept.
    always_ff @(posedge Clk) begin
        if (accept) begin
            lat_addr  <= Addr[ADDR_BITS-1:0];
            lat_write <= Req_Write;
            lat_data  <= Data_From_CPU;
        end
    end

    // The RAM is addressed from the live bus while idle so that its registered
    // read is already valid during ACCESS, even with zero wait states.
    assign ram_addr = (state == IDLE) ? Addr[ADDR_BITS-1:0] : lat_addr;
    assign ram_we   = (state == ACCESS) && lat_write && !Reset;

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .Clk        (Clk),
        .Write_En   (ram_we),
        .Addr       (ram_addr),
        .Write_Data (lat_data),
        .Read_Data  (ram_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Data_to_CPU <= '0;
        end else if (state == ACCESS && !lat_write) begin
            Data_to_CPU <= ram_rdata;
        end
    end

    assign Ready = (state == RESPOND);
    assign Busy  = (state != IDLE);

    generate
        if (ADDR_BITS < 16) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^Addr[15:ADDR_BITS];
        end
    endgenerate

endmodule
